// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter using shift-add-3 ("double dabble").
// One input bit is consumed per SHIFT cycle. bcd_out and overflow update only
// on the edge that enters DONE, so a free-running display scanner never sees
// partial results.
// Optional build macro: BCD_AUTO_START_EN. When it is defined, a conversion
// relaunches from IDLE/DONE on every opportunity and the start port is ignored.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    adjusted;
  logic [BW-1:0]    scratch_nxt;
  logic             sticky;
  logic             sticky_nxt;
  logic [CW-1:0]    count;
  logic             req;

`ifdef BCD_AUTO_START_EN
  assign req = start | 1'b1;
`else
  assign req = start;
`endif

  // One shift-add-3 step: correct every digit in parallel, then shift the
  // whole {scratch, shreg} chain left by one bit. The bit that leaves the top
  // of scratch records that the value does not fit in DIGITS digits.
  always_comb begin
    adjusted = scratch;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5)
        adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
    {scratch_nxt, shreg_nxt} = {adjusted, shreg} << 1;
    sticky_nxt = sticky | adjusted[BW-1];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      shreg    <= '0;
      scratch  <= '0;
      sticky   <= 1'b0;
      count    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (req) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            shreg   <= bin_in;
            scratch <= '0;
            sticky  <= 1'b0;
            count   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          shreg   <= shreg_nxt;
          scratch <= scratch_nxt;
          sticky  <= sticky_nxt;
          count   <= count + 1'b1;
          if (count == LAST) begin
            // The result is taken from the post-shift values so that the
            // final bit is already included.
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd_out  <= sticky_nxt ? '1 : scratch_nxt;
            overflow <= sticky_nxt;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
